operand_select_pipe: RTL and testbench
======================================

Name: operand_select_pipe

Overview:
- Parametrised, registered N-way operand selector for the multicycle datapath; next generation of the ALU-source mux.
- Selects one of NUM_INPUTS words and pushes it through a STAGES-deep valid/ready register pipeline.
- Adds backpressure, flush, and out-of-range select detection with error counting.
- Sits between the register-file/immediate/PC sources and the ALU operand input.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_INPUTS, 3, number of selectable inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_INPUTS.
- STAGES, 1, pipeline depth; legal range 1..4.
- DEFAULT_VALUE, 32'h0, value emitted for an out-of-range select, truncated to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- sel  in  SEL_W  input index; sampled on accept.
- data_in  in  NUM_INPUTS*WIDTH  flattened inputs; input i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- flush  in  1  discard all in-flight beats.
- result  out  WIDTH  selected word at the pipeline head.
- sel_err  out  1  the beat at the head had an out-of-range select; valid only with out_valid.
- out_valid  out  1  a beat is held at the head.
- out_ready  in  1  downstream consumes the head beat.
- err_count  out  16  saturating count of accepted out-of-range beats.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. It clears all stage valid bits, stage data, stage err bits, result, sel_err and err_count to 0. out_valid is 0 the cycle after reset is sampled. Reset asserted mid-transfer drops every in-flight beat.
- Accept: a beat is accepted on a clk edge when in_valid && in_ready.
- Selection is combinational on the accept cycle. If sel < NUM_INPUTS, the beat carries data_in[sel]. Otherwise it carries DEFAULT_VALUE with its err bit set to 1.
- Pipeline: stages 0..STAGES-1, each holding valid, data and err.
- A stage loads from upstream when it is empty or when its contents move on the same edge. Stage k moves on when stage k+1 loads; the last stage moves on when out_ready is 1.
- in_ready = !flush && (!v0 || stage0 moves on this cycle). in_ready is combinational from out_ready through the stage chain; no registered ready.
- Latency: with out_ready held at 1, a beat accepted at edge N appears on result/out_valid after edge N+STAGES-1. For STAGES=1 it is visible the cycle after acceptance.
- Throughput is 1 beat per cycle at steady state. No beat is duplicated or dropped except by flush or reset.
- Stall: while out_valid && !out_ready, result and sel_err hold stable. Upstream stages fill until in_ready falls. A full pipeline with out_ready=1 accepts a new beat in the same cycle (pass-through of ready).
- Flush:
  - Clears all valid bits on the edge it is sampled; data registers keep their values.
  - in_ready is 0 while flush=1, so no beat is accepted that cycle.
  - A head beat presented with out_ready=1 in the flush cycle still counts as consumed downstream.
  - err_count is not affected.
- err_count:
  - Increments by 1 on each accepted beat with an out-of-range select.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Empty stages: result holds the last loaded head value; downstream must qualify it with out_valid.
- Output registers reset to 0, not to DEFAULT_VALUE.

Decomposition:
- Shared package holds:
  - ALU source select encodings: SRC_REG=0, SRC_IMM=1, SRC_PC=2.
  - err_count width (16) and its saturation constant.
- One natural sub-module, select_pipe_stage: a single valid/data/err register with load/hold logic, instantiated STAGES times via generate.
- Select decode and err_count live in the top.

Test Plan:
- STAGES=1, out_ready=1, in_valid=1, sel=1, data_in={32'hC,32'hB,32'hA} (input0=A) -> result=32'hB with out_valid=1 after one edge; next cycle sel=0 -> result=32'hA.
- STAGES=3, five back-to-back beats 1..5 with out_ready=1 -> first beat appears 3 cycles after its acceptance, then 1,2,3,4,5 on consecutive cycles with no gaps.
- STAGES=2, out_ready=0 for 6 cycles with in_valid=1 -> in_ready falls after 2 accepts, result holds first beat stable; releasing out_ready -> beats drain in order with none lost or duplicated.
- NUM_INPUTS=3, sel=3, DEFAULT_VALUE=32'hDEAD_BEEF -> result=32'hDEADBEEF, sel_err=1, err_count=1; 70000 further bad accepts -> err_count saturates at 16'hFFFF.
- STAGES=3 with pipeline full, assert flush with in_valid=1 -> out_valid=0 next cycle, flushed-cycle beat not accepted, err_count unchanged.
- Assert reset mid-stream with err_count=5 and pipeline full -> all outputs 0 after the edge; first beat after reset released behaves as in scenario 1.

Source files
------------

// File: rtl/operand_select_pipe_pkg.sv
// Shared constants for the ALU operand select pipeline: source encodings
// and the error-counter geometry with its saturating increment.
package operand_select_pipe_pkg;

  typedef enum logic [1:0] {
    SRC_REG = 2'd0,
    SRC_IMM = 2'd1,
    SRC_PC  = 2'd2
  } alu_src_e;

  localparam int ERR_CNT_W = 16;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    return (cnt == ERR_CNT_MAX) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/select_pipe_stage.sv
// One valid/data/err pipeline register. Data and err only change on a valid
// load, so an emptied stage keeps presenting the last beat it held.
module select_pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             err_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             err_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    err_d   = err_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
        err_d  = err_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign err_o   = err_q;

endmodule

// File: rtl/operand_select_pipe.sv
// N-way operand selector feeding a STAGES-deep valid/ready register pipeline
// with flush, out-of-range select flagging and a saturating error counter.
module operand_select_pipe
  import operand_select_pipe_pkg::*;
#(
  parameter int          WIDTH         = 32,
  parameter int          NUM_INPUTS    = 3,
  parameter int          SEL_W         = 2,
  parameter int          STAGES        = 1,
  parameter logic [31:0] DEFAULT_VALUE = 32'h0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [SEL_W-1:0]            sel,
  input  logic [NUM_INPUTS*WIDTH-1:0] data_in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [WIDTH-1:0]            result,
  output logic                        sel_err,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ERR_CNT_W-1:0]        err_count
);

  localparam logic [WIDTH-1:0] DEFAULT_W = WIDTH'(DEFAULT_VALUE);

  logic             accept;
  logic [WIDTH-1:0] pick_data;
  logic             pick_err;

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_err;
  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [STAGES:0]   stage_ready;

  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    pick_data = DEFAULT_W;
    pick_err  = 1'b1;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (int'(sel) == i) begin
        pick_data = data_in[i*WIDTH +: WIDTH];
        pick_err  = 1'b0;
      end
    end
  end

  // A stage can take a beat if it is empty or its occupant leaves this edge;
  // walking from the head back makes ready pass straight through a full pipe.
  always_comb begin
    stage_ready         = '0;
    stage_ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stage_ready[k] = !stage_valid[k] || stage_ready[k+1];
    end
  end

  assign in_ready = !flush && stage_ready[0];
  assign accept   = in_valid && in_ready;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             up_err;

    if (gi == 0) begin : g_first
      assign up_valid = accept;
      assign up_data  = pick_data;
      assign up_err   = pick_err;
    end else begin : g_rest
      assign up_valid = stage_valid[gi-1];
      assign up_data  = stage_data[gi-1];
      assign up_err   = stage_err[gi-1];
    end

    select_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .flush_i (flush),
      .load_i  (stage_ready[gi]),
      .valid_i (up_valid),
      .data_i  (up_data),
      .err_i   (up_err),
      .valid_o (stage_valid[gi]),
      .data_o  (stage_data[gi]),
      .err_o   (stage_err[gi])
    );
  end

  always_comb begin
    err_count_d = err_count_q;
    if (accept && pick_err) begin
      err_count_d = sat_inc(err_count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= '0;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign result    = stage_data[STAGES-1];
  assign sel_err   = stage_err[STAGES-1];
  assign out_valid = stage_valid[STAGES-1];
  assign err_count = err_count_q;

endmodule

// File: tb/tb_operand_select_pipe.sv
// Directed bench: three pipeline depths (1, 2, 3) driven independently from
// one linear stimulus sequence with hand-computed expected values.
module tb_operand_select_pipe;

  logic clk = 1'b0;
  logic reset;

  logic [1:0]  sel1, sel2, sel3;
  logic [95:0] din1, din2, din3;
  logic        iv1, iv2, iv3;
  logic        fl1, fl2, fl3;
  logic        or1, or2, or3;
  logic        ir1, ir2, ir3;
  logic [31:0] res1, res2, res3;
  logic        se1, se2, se3;
  logic        ov1, ov2, ov3;
  logic [15:0] ec1, ec2, ec3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  operand_select_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .STAGES(1),
                        .DEFAULT_VALUE(32'hDEAD_BEEF)) u_s1 (
    .clk(clk), .reset(reset), .sel(sel1), .data_in(din1), .in_valid(iv1),
    .in_ready(ir1), .flush(fl1), .result(res1), .sel_err(se1),
    .out_valid(ov1), .out_ready(or1), .err_count(ec1));

  operand_select_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .STAGES(2),
                        .DEFAULT_VALUE(32'hDEAD_BEEF)) u_s2 (
    .clk(clk), .reset(reset), .sel(sel2), .data_in(din2), .in_valid(iv2),
    .in_ready(ir2), .flush(fl2), .result(res2), .sel_err(se2),
    .out_valid(ov2), .out_ready(or2), .err_count(ec2));

  operand_select_pipe #(.WIDTH(32), .NUM_INPUTS(3), .SEL_W(2), .STAGES(3),
                        .DEFAULT_VALUE(32'hDEAD_BEEF)) u_s3 (
    .clk(clk), .reset(reset), .sel(sel3), .data_in(din3), .in_valid(iv3),
    .in_ready(ir3), .flush(fl3), .result(res3), .sel_err(se3),
    .out_valid(ov3), .out_ready(or3), .err_count(ec3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    sel1 = 2'd0; sel2 = 2'd0; sel3 = 2'd0;
    din1 = '0;   din2 = '0;   din3 = '0;
    iv1 = 1'b0;  iv2 = 1'b0;  iv3 = 1'b0;
    fl1 = 1'b0;  fl2 = 1'b0;  fl3 = 1'b0;
    or1 = 1'b1;  or2 = 1'b1;  or3 = 1'b1;
    tick();
    tick();
    check("rst_ov1", ov1, 0);
    check("rst_res1", res1, 0);
    check("rst_err1", se1, 0);
    check("rst_cnt1", ec1, 0);
    check("rst_ov3", ov3, 0);
    check("rst_res3", res3, 0);
    reset = 1'b0;

    // Single stage: select input 1 then input 0
    din1 = {32'hC, 32'hB, 32'hA};
    sel1 = 2'd1;
    iv1  = 1'b1;
    #1;
    check("s1_in_ready", ir1, 1);
    tick();
    check("s1_sel1_res", res1, 32'hB);
    check("s1_sel1_ov", ov1, 1);
    check("s1_sel1_err", se1, 0);
    sel1 = 2'd0;
    tick();
    check("s1_sel0_res", res1, 32'hA);
    iv1 = 1'b0;
    tick();
    check("s1_idle_ov", ov1, 0);
    check("s1_idle_hold", res1, 32'hA);

    // Three stages: beats 1..5 back to back, head appears after two more edges
    sel3 = 2'd0;
    or3  = 1'b1;
    for (int c = 0; c < 8; c++) begin
      iv3  = (c < 5);
      din3 = {64'h0, 32'(c + 1)};
      tick();
      if (c >= 2 && c <= 6) begin
        check("s3_stream_ov", ov3, 1);
        check("s3_stream_data", res3, 32'(c - 1));
      end else begin
        check("s3_stream_empty", ov3, 0);
      end
    end
    iv3 = 1'b0;

    // Two stages: stall downstream, ready falls after two accepts
    or2  = 1'b0;
    iv2  = 1'b1;
    sel2 = 2'd0;
    for (int c = 0; c < 6; c++) begin
      din2 = {64'h0, 32'(10 + c)};
      #1;
      check("s2_in_ready", ir2, (c < 2) ? 32'd1 : 32'd0);
      tick();
      if (c >= 1) begin
        check("s2_stall_ov", ov2, 1);
        check("s2_stall_res", res2, 32'd10);
      end
    end
    iv2 = 1'b0;
    or2 = 1'b1;
    tick();
    check("s2_drain_ov", ov2, 1);
    check("s2_drain_res", res2, 32'd11);
    tick();
    check("s2_drain_empty", ov2, 0);

    // Out-of-range select and error counter saturation
    sel1 = 2'd3;
    iv1  = 1'b1;
    or1  = 1'b1;
    tick();
    check("bad_res", res1, 32'hDEAD_BEEF);
    check("bad_err", se1, 1);
    check("bad_cnt1", ec1, 1);
    repeat (65533) tick();
    check("cnt_fffe", ec1, 32'hFFFE);
    tick();
    check("cnt_ffff", ec1, 32'hFFFF);
    repeat (5) tick();
    check("cnt_sat", ec1, 32'hFFFF);
    iv1 = 1'b0;

    // Three stages: five bad beats leave err_count=5 and the pipe full
    or3  = 1'b1;
    sel3 = 2'd3;
    iv3  = 1'b1;
    repeat (5) tick();
    check("s3_cnt5", ec3, 5);
    check("s3_full_ov", ov3, 1);
    check("s3_full_err", se3, 1);
    check("s3_full_res", res3, 32'hDEAD_BEEF);
    or3 = 1'b0;
    #1;
    check("s3_full_stall_ready", ir3, 0);
    or3 = 1'b1;
    #1;
    check("s3_full_pass_ready", ir3, 1);

    // Flush with in_valid high: nothing accepted, valids cleared, count kept
    or3 = 1'b0;
    fl3 = 1'b1;
    #1;
    check("flush_ready", ir3, 0);
    tick();
    check("flush_ov", ov3, 0);
    check("flush_cnt", ec3, 5);
    fl3 = 1'b0;
    iv3 = 1'b0;
    or3 = 1'b1;
    repeat (3) tick();
    check("flush_no_accept", ov3, 0);
    check("flush_cnt_after", ec3, 5);

    // Refill with a stalled head, then reset mid-stream
    or3  = 1'b0;
    sel3 = 2'd0;
    din3 = {64'h0, 32'h55};
    iv3  = 1'b1;
    repeat (3) tick();
    check("refill_ov", ov3, 1);
    check("refill_res", res3, 32'h55);
    check("refill_ready", ir3, 0);
    reset = 1'b1;
    tick();
    check("mid_rst_ov3", ov3, 0);
    check("mid_rst_res3", res3, 0);
    check("mid_rst_err3", se3, 0);
    check("mid_rst_cnt3", ec3, 0);
    check("mid_rst_cnt1", ec1, 0);
    check("mid_rst_res1", res1, 0);
    iv3 = 1'b0;
    or3 = 1'b1;
    reset = 1'b0;

    // First beat after reset behaves like a fresh start
    din1 = {32'hC, 32'hB, 32'hA};
    sel1 = 2'd1;
    iv1  = 1'b1;
    tick();
    check("post_rst_res", res1, 32'hB);
    check("post_rst_ov", ov1, 1);
    check("post_rst_err", se1, 0);
    check("post_rst_cnt", ec1, 0);
    iv1 = 1'b0;
    repeat (3) tick();
    check("post_rst_dropped", ov3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
